// File: rtl/cpu_run_ctrl.sv
// Run controller: program load, reset/start sequencing and cycle limit.
// Optional halt-on-zero-instruction stop: define RUN_CTRL_HALT_ON_ZERO_EN.
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  cycle_limit_i,
  input  logic [31:0]       instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              cpu_start_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   words_o,
  output logic [CNT_W-1:0]  cycles_o,
  output logic              err_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(IMEM_DEPTH);

  state_e            state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cpu_start_q, cpu_start_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic              err_q, err_d;
  logic              halted_q, halted_d;

  logic              accept;
  logic              halt_hit;
  logic              limit_hit;
  logic [ADDR_W:0]   base;
  logic [CNT_W-1:0]  cycles_inc;

  assign accept     = ld_valid_i & ld_ready_q & ~abort_i;
  assign cycles_inc = cycles_q + 1'b1;
  assign limit_hit  = (limit_q != '0) && (cycles_inc == limit_q);
  assign base       = (state_q == IDLE) ? '0 : words_q;

`ifdef RUN_CTRL_HALT_ON_ZERO_EN
  // a zero word past the first CPU edge is treated as end of program
  assign halt_hit = (instr_i == 32'h0) && (cycles_q != '0);
`else
  logic unused_instr;
  assign unused_instr = ^instr_i;
  assign halt_hit     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    cycles_d     = cycles_q;
    limit_d      = limit_q;
    err_d        = err_q;
    halted_d     = halted_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (state_q == IDLE) begin
              err_d    = 1'b0;
              halted_d = 1'b0;
            end
            imem_we_d    = 1'b1;
            imem_addr_d  = base[ADDR_W-1:0];
            imem_wdata_d = ld_data_i;
            words_d      = base + 1'b1;
            if (ld_last_i) begin
              state_d = IDLE;
            end else if (words_d == FULL) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else if (go_i && state_q == IDLE) begin
            state_d  = RUN;
            cycles_d = '0;
            limit_d  = cycle_limit_i;
          end
        end
        RUN: begin
          if (cycles_q != '1) cycles_d = cycles_inc;
          if (limit_hit || halt_hit) state_d = DONE;
          if (halt_hit) halted_d = 1'b1;
        end
        DONE: begin
          if (go_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    ld_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    cpu_rst_n_d = (state_d == RUN) || (state_d == DONE);
    cpu_start_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ld_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_start_q  <= 1'b0;
      words_q      <= '0;
      cycles_q     <= '0;
      limit_q      <= '0;
      err_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_ready_q   <= ld_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_start_q  <= cpu_start_d;
      words_q      <= words_d;
      cycles_q     <= cycles_d;
      limit_q      <= limit_d;
      err_q        <= err_d;
      halted_q     <= halted_d;
    end
  end

  assign state_o      = state_q;
  assign ld_ready_o   = ld_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign cpu_start_o  = cpu_start_q;
  assign words_o      = words_q;
  assign cycles_o     = cycles_q;
  assign err_o        = err_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: reference model plus toy CPU fetch model.
// Halt expectations follow RUN_CTRL_HALT_ON_ZERO_EN.
module tb_cpu_run_ctrl;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_RUN  = 2;
  localparam int ST_DONE = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [31:0] ld_data_i;
  logic        ld_last_i;
  logic        go_i;
  logic        abort_i;
  logic [15:0] cycle_limit_i;
  logic [31:0] instr_i;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rst_n_o;
  logic        cpu_start_o;
  logic [1:0]  state_o;
  logic [8:0]  words_o;
  logic [15:0] cycles_o;
  logic        err_o;
  logic        halted_o;

  cpu_run_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ld_valid_i    (ld_valid_i),
    .ld_ready_o    (ld_ready_o),
    .ld_data_i     (ld_data_i),
    .ld_last_i     (ld_last_i),
    .go_i          (go_i),
    .abort_i       (abort_i),
    .cycle_limit_i (cycle_limit_i),
    .instr_i       (instr_i),
    .imem_we_o     (imem_we_o),
    .imem_addr_o   (imem_addr_o),
    .imem_wdata_o  (imem_wdata_o),
    .cpu_rst_n_o   (cpu_rst_n_o),
    .cpu_start_o   (cpu_start_o),
    .state_o       (state_o),
    .words_o       (words_o),
    .cycles_o      (cycles_o),
    .err_o         (err_o),
    .halted_o      (halted_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  int          m_st, m_words, m_cyc, m_lim, pc;
  logic        m_we, m_err, m_halt;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [31:0] mem [256];

  logic [72:0] obs;
  assign obs = {state_o, ld_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
                cpu_rst_n_o, cpu_start_o, words_o, cycles_o, err_o, halted_o};

  function automatic logic [72:0] expv();
    logic rdy, rstn, strt;
    rdy  = (m_st == ST_IDLE) || (m_st == ST_LOAD);
    rstn = (m_st == ST_RUN) || (m_st == ST_DONE);
    strt = (m_st == ST_RUN);
    return {2'(m_st), rdy, m_we, 8'(m_addr), m_wdata, rstn, strt,
            9'(m_words), 16'(m_cyc), m_err, m_halt};
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_words = 0; m_cyc = 0; m_lim = 0; pc = 0;
    m_we = 0; m_err = 0; m_halt = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l,
                      input logic g, input logic a);
    int  old_st, b;
    logic hit, hlt;
    ld_valid_i = v; ld_data_i = d; ld_last_i = l; go_i = g; abort_i = a;
    instr_i = mem[pc % 256];
    @(posedge clk_i);
    old_st = m_st;
    m_we   = 0;
    hlt    = 0;
`ifdef RUN_CTRL_HALT_ON_ZERO_EN
    hlt = (m_st == ST_RUN) && (instr_i == 32'h0) && (m_cyc >= 1);
`endif
    hit = (m_st == ST_RUN) && (m_lim != 0) && (m_cyc + 1 == m_lim);
    if (a) begin
      m_st = ST_IDLE;
    end else if ((m_st == ST_IDLE || m_st == ST_LOAD) && v) begin
      b = (m_st == ST_IDLE) ? 0 : m_words;
      if (m_st == ST_IDLE) begin m_err = 0; m_halt = 0; end
      mem[b] = d; m_we = 1; m_addr = b; m_wdata = d; m_words = b + 1;
      if (l) m_st = ST_IDLE;
      else if (m_words == 256) begin m_st = ST_IDLE; m_err = 1; end
      else m_st = ST_LOAD;
    end else if (m_st == ST_IDLE && g) begin
      m_st = ST_RUN; m_cyc = 0; m_lim = int'(cycle_limit_i);
    end else if (m_st == ST_RUN) begin
      if (m_cyc < 65535) m_cyc++;
      if (hit || hlt) m_st = ST_DONE;
      if (hlt) m_halt = 1;
    end else if (m_st == ST_DONE && g) begin
      m_st = ST_IDLE;
    end
    if (old_st == ST_RUN) pc++;
    if (m_st != ST_RUN && m_st != ST_DONE) pc = 0;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 0; ld_valid_i = 0; ld_data_i = 0; ld_last_i = 0;
    go_i = 0; abort_i = 0; cycle_limit_i = 0; instr_i = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, expv());
    end
    @(negedge clk_i);
    rst_i = 1;
    idle_step();
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_load_short();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom | 32'h1, 1'(i == 2), 1'b0, 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL load_short[%0d]: got %h want %h", i, obs, expv());
      end
    end
    idle_step();
    checks++;
    if (words_o !== 9'd3 || state_o !== 2'b00 || err_o !== 1'b0 ||
        imem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL load_short_end: got words=%0d st=%0d err=%b we=%b want 3 0 0 0",
               words_o, state_o, err_o, imem_we_o);
    end
  endtask

  task automatic test_load_overflow();
    int n;
    n = 0;
    for (int i = 0; i < 2000 && n < 256; i++) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
        n++;
      end else begin
        idle_step();
      end
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL load_ovf[%0d]: got %h want %h", n, obs, expv());
      end
    end
    idle_step();
    checks++;
    if (words_o !== 9'd256 || err_o !== 1'b1 || state_o !== 2'b00 ||
        ld_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL load_ovf_end: got words=%0d err=%b st=%0d rdy=%b want 256 1 0 1",
               words_o, err_o, state_o, ld_ready_o);
    end
  endtask

  task automatic test_run_limit();
    cycle_limit_i = 16'd30;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL run_lim[%0d]: got %h want %h", i, obs, expv());
      end
      idle_step();
    end
    checks++;
    if (state_o !== 2'b11 || cycles_o !== 16'd30 || cpu_start_o !== 1'b0 ||
        cpu_rst_n_o !== 1'b1) begin
      errors++;
      $display("FAIL run_lim_done: got st=%0d cyc=%0d start=%b rstn=%b want 3 30 0 1",
               state_o, cycles_o, cpu_start_o, cpu_rst_n_o);
    end
    idle_step();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state_o !== 2'b00 || cpu_rst_n_o !== 1'b0 || obs !== expv()) begin
      errors++;
      $display("FAIL run_lim_back: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++)
      step(1'b1, (i == 4) ? 32'h0 : ($urandom | 32'h1), 1'(i == 4), 1'b0, 1'b0);
    cycle_limit_i = 16'd0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      idle_step();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL halt[%0d]: got %h want %h", i, obs, expv());
      end
    end
    checks++;
`ifdef RUN_CTRL_HALT_ON_ZERO_EN
    if (state_o !== 2'b11 || halted_o !== 1'b1 || cycles_o !== 16'd5) begin
      errors++;
      $display("FAIL halt_end: got st=%0d halted=%b cyc=%0d want 3 1 5",
               state_o, halted_o, cycles_o);
    end
`else
    if (state_o !== 2'b10 || halted_o !== 1'b0 || cycles_o !== 16'd100) begin
      errors++;
      $display("FAIL halt_end: got st=%0d halted=%b cyc=%0d want 2 0 100",
               state_o, halted_o, cycles_o);
    end
`endif
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int w;
    step(1'b1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    w = m_words;
    step(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b1);
    checks++;
    if (imem_we_o !== 1'b0 || state_o !== 2'b00 || cpu_rst_n_o !== 1'b0 ||
        words_o !== 9'(w) || obs !== expv()) begin
      errors++;
      $display("FAIL abort_load: got %h want %h", obs, expv());
    end
    cycle_limit_i = 16'd50;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (7) idle_step();
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    checks++;
    if (state_o !== 2'b00 || cpu_rst_n_o !== 1'b0 || cpu_start_o !== 1'b0 ||
        imem_we_o !== 1'b0 || obs !== expv()) begin
      errors++;
      $display("FAIL abort_run: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_random();
    logic v, g, a;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(2) == 0);
      g = ($urandom_range(6) == 0);
      a = ($urandom_range(60) == 0);
      cycle_limit_i = 16'($urandom_range(40));
      step(v, ($urandom_range(7) == 0) ? 32'h0 : $urandom, ($urandom_range(9) == 0), g, a);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle_limit_i = 16'd0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (4) idle_step();
    #2;
    rst_i = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== expv() || cpu_rst_n_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, expv());
    end
    @(negedge clk_i);
    rst_i = 1;
    idle_step();
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL async_reset_after: got %h want %h", obs, expv());
    end
  endtask

  initial begin
    test_reset();
    test_load_short();
    test_load_overflow();
    test_run_limit();
    test_halt();
    test_abort();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
